// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle MIPS CPU: sequences IF/ID/EX/MEM/WB and drives datapath controls.
// Optional ILLEGAL_HALT_EN: illegal instructions park the FSM in S_HALT and raise IllegalInst.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
`ifdef ILLEGAL_HALT_EN
  output logic       IllegalInst,
`endif
  output logic       InstDone
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic       is_r, r_legal, r_shift, op_legal;
  logic       is_lw, is_sw, is_andi;
  logic [2:0] alu_base;
  logic       alu_hit;

  assign is_r     = (OpCode == 6'h00);
  assign is_lw    = (OpCode == 6'h23);
  assign is_sw    = (OpCode == 6'h2b);
  assign is_andi  = (OpCode == 6'h0c);
  assign r_legal  = Funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a, 6'h2b};
  assign r_shift  = Funct inside {6'h00, 6'h02, 6'h03};
  assign op_legal = (is_r && r_legal) ||
                    (OpCode inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f,
                                    6'h23, 6'h2b});

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 4'b0000;
    PCSource    = 2'b00;
    InstDone    = 1'b0;
    alu_base    = 3'b000;
    alu_hit     = 1'b0;
`ifdef ILLEGAL_HALT_EN
    IllegalInst = 1'b0;
`endif

    if (!reset) begin
      ExtOp = !is_andi;
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
          state_d = S_ID;
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          state_d = S_EX;
          if (OpCode == 6'h02 || OpCode == 6'h03) begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            InstDone = 1'b1;
            state_d  = S_IF;
            if (OpCode == 6'h03) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
            end
          end else if (is_r && (Funct == 6'h08 || Funct == 6'h09)) begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
            InstDone = 1'b1;
            state_d  = S_IF;
            if (Funct == 6'h09) begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              MemtoReg = 2'b10;
            end
          end else if (!op_legal) begin
`ifdef ILLEGAL_HALT_EN
            state_d  = S_HALT;
`else
            InstDone = 1'b1;
            state_d  = S_IF;
`endif
          end
        end
        S_EX: begin
          alu_hit = 1'b1;
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          state_d = S_WB;
          case (OpCode)
            6'h00: begin
              ALUSrcA  = r_shift ? 2'b10 : 2'b01;
              ALUSrcB  = 2'b00;
              alu_base = 3'b010;
            end
            6'h23, 6'h2b: state_d = S_MEM;
            6'h04: begin
              ALUSrcB     = 2'b00;
              alu_base    = 3'b001;
              PCWriteCond = 1'b1;
              PCSource    = 2'b01;
              InstDone    = 1'b1;
              state_d     = S_IF;
            end
            6'h08: alu_base = 3'b000;
            6'h09: alu_base = 3'b101;
            6'h0c: alu_base = 3'b011;
            6'h0a, 6'h0b: alu_base = 3'b100;
            6'h0f: LuiOp = 1'b1;
            default: begin
              alu_hit = 1'b0;
              ALUSrcA = 2'b00;
              ALUSrcB = 2'b00;
              state_d = S_IF;
            end
          endcase
          // andi is a zero-extended logical op, so it is flagged unsigned despite OpCode[0]=0
          if (alu_hit) ALUOp = {OpCode[0] | is_andi, alu_base};
        end
        S_MEM: begin
          IorD = 1'b1;
          if (is_lw) begin
            MemRead = 1'b1;
            state_d = S_WB;
          end else if (is_sw) begin
            MemWrite = 1'b1;
            InstDone = 1'b1;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          InstDone = 1'b1;
          RegDst   = is_r  ? 2'b01 : 2'b00;
          MemtoReg = is_lw ? 2'b01 : 2'b00;
        end
`ifdef ILLEGAL_HALT_EN
        S_HALT: begin
          IllegalInst = 1'b1;
          state_d     = S_HALT;
        end
`endif
        default: state_d = S_IF;
      endcase
    end
  end

endmodule
